// File: rtl/child_resp_collector.sv
// Round-robin fan-in of NUM_CHILD valid/ready response streams into one tagged stream.
// A single registered output stage sustains one word per cycle.
module child_resp_collector #(
    parameter int NUM_CHILD = 5,
    parameter int DATA_W    = 16,
    parameter int IDX_W     = 3,
    parameter int CNT_W     = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_CHILD-1:0]        in_valid,
    output logic [NUM_CHILD-1:0]        in_ready,
    input  logic [NUM_CHILD*DATA_W-1:0] in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_W-1:0]           out_data,
    output logic [IDX_W-1:0]            out_idx,
    output logic [CNT_W-1:0]            xfer_count
);

    localparam logic [IDX_W:0]   NUM_LIM   = (IDX_W+1)'(NUM_CHILD);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_CHILD - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    logic [IDX_W-1:0]     ptr_r;
    logic                 out_valid_r;
    logic [DATA_W-1:0]    out_data_r;
    logic [IDX_W-1:0]     out_idx_r;
    logic [CNT_W-1:0]     xfer_count_r;

    logic                 load_en_s;
    logic                 grant_vld_s;
    logic [IDX_W-1:0]     grant_idx_s;
    logic [DATA_W-1:0]    grant_data_s;
    logic [NUM_CHILD-1:0] in_ready_s;
    logic                 in_hs_s;
    logic                 out_hs_s;
    logic [IDX_W-1:0]     ptr_next_s;
    logic [IDX_W:0]       sum_s;
    logic [IDX_W:0]       wrap_s;

    assign load_en_s = !out_valid_r || out_ready;
    assign out_hs_s  = out_valid_r && out_ready;
    assign in_hs_s   = !rst && load_en_s && grant_vld_s;

    // Round-robin search from ptr; scanning far-to-near lets the nearest requester win
    always_comb begin
        grant_vld_s = 1'b0;
        grant_idx_s = '0;
        sum_s       = '0;
        wrap_s      = '0;
        for (int k = NUM_CHILD - 1; k >= 0; k--) begin
            sum_s = {1'b0, ptr_r} + (IDX_W+1)'(k);
            if (sum_s >= NUM_LIM) begin
                wrap_s = sum_s - NUM_LIM;
            end else begin
                wrap_s = sum_s;
            end
            grant_idx_s = in_valid[wrap_s[IDX_W-1:0]] ? wrap_s[IDX_W-1:0] : grant_idx_s;
            grant_vld_s = grant_vld_s | in_valid[wrap_s[IDX_W-1:0]];
        end
    end

    // Select the granted child's data word
    always_comb begin
        grant_data_s = '0;
        for (int i = 0; i < NUM_CHILD; i++) begin
            grant_data_s = (grant_idx_s == IDX_W'(i)) ? in_data[i*DATA_W +: DATA_W] : grant_data_s;
        end
    end

    // One-hot accept toward the granted child, suppressed during reset
    always_comb begin
        in_ready_s = '0;
        if (in_hs_s) begin
            in_ready_s[grant_idx_s] = 1'b1;
        end else begin
            in_ready_s = '0;
        end
    end

    // Pointer moves to the child after the one just granted
    always_comb begin
        ptr_next_s = ptr_r;
        if (grant_idx_s == LAST_IDX) begin
            ptr_next_s = '0;
        end else begin
            ptr_next_s = grant_idx_s + IDX_W'(1);
        end
    end

    // Output register and round-robin pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_idx_r   <= '0;
            ptr_r       <= '0;
        end else if (in_hs_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= grant_data_s;
            out_idx_r   <= grant_idx_s;
            ptr_r       <= ptr_next_s;
        end else if (out_hs_s) begin
            out_valid_r <= 1'b0;
        end
    end

    // Saturating count of delivered words
    always_ff @(posedge clk) begin
        if (rst) begin
            xfer_count_r <= '0;
        end else if (out_hs_s && (xfer_count_r != CNT_MAX)) begin
            xfer_count_r <= xfer_count_r + CNT_W'(1);
        end
    end

    assign in_ready   = in_ready_s;
    assign out_valid  = out_valid_r;
    assign out_data   = out_data_r;
    assign out_idx    = out_idx_r;
    assign xfer_count = xfer_count_r;

endmodule
